output_port_buffer: RTL

OUTPUT_PORT_BUFFER -- requirements
Module: output_port_buffer

---
 rtl/noc_pkg.sv | 32 +++
 rtl/output_port_buffer_fifo.sv | 64 ++++++
 rtl/output_port_buffer.sv | 83 ++++++++
 3 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices, flit type and the
// highest-index-wins one-hot picker used by the output buffers.
package noc_pkg;

    localparam int NUM_PORTS = 5;

    localparam int LOCAL = 0;
    localparam int NORTH = 1;
    localparam int EAST  = 2;
    localparam int SOUTH = 3;
    localparam int WEST  = 4;

    localparam int FLIT_W = 32;

    typedef logic [FLIT_W-1:0] flit_t;

    // Ascending scan so the highest set bit overwrites lower ones.
    function automatic logic [NUM_PORTS-1:0] pick_hi(
        input logic [NUM_PORTS-1:0] req
    );
        logic [NUM_PORTS-1:0] r;
        r = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (req[k]) begin
                r    = '0;
                r[k] = 1'b1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/output_port_buffer_fifo.sv
// flit_fifo: circular flit storage with wrapping pointers, occupancy
// count and flags. Storage is not reset; empty masks stale entries.
module flit_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             pop,
    output logic [WIDTH-1:0] rd_data,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             empty
);

    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Flit storage write; contents deliberately left unreset.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Occupancy: net change only when exactly one of push/pop occurs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Flags and head flit, zeroed while nothing is stored.
    always_comb begin
        full    = (count == FULL_CNT);
        empty   = (count == '0);
        rd_data = empty ? '0 : mem[rd_ptr];
    end

endmodule

// File: rtl/output_port_buffer.sv
// Router output port buffer: one-hot source mux, ack and a flit FIFO.
// Optional same-cycle empty-buffer bypass: OUTPUT_BUFFER_BYPASS_EN.
module output_port_buffer
    import noc_pkg::*;
#(
    parameter int DATA_WIDTH = $bits(flit_t),
    parameter int DEPTH      = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            write_i,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_i,
    output logic [NUM_PORTS-1:0]            ack_o,
    output logic [DATA_WIDTH-1:0]           data_o,
    output logic                            valid_o,
    input  logic                            ready_i,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(DEPTH):0]          count_o
);

    logic [NUM_PORTS-1:0]  sel;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [DATA_WIDTH-1:0] head;
    logic                  req;
    logic                  pop;
    logic                  push;
    logic                  fifo_push;
    logic                  bypass;

    // Pick the granted source and route its flit.
    always_comb begin
        sel      = pick_hi(write_i);
        sel_data = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            if (sel[k]) begin
                sel_data = data_i[k*DATA_WIDTH +: DATA_WIDTH];
            end
        end
    end

`ifdef OUTPUT_BUFFER_BYPASS_EN
    // Empty buffer with a ready link: flit passes straight through.
    always_comb begin
        req       = rst_n && (write_i != '0);
        bypass    = req && empty_o && ready_i;
        valid_o   = !empty_o || bypass;
        data_o    = bypass ? sel_data : head;
        pop       = !empty_o && ready_i;
        push      = req && (!full_o || pop);
        fifo_push = push && !bypass;
        ack_o     = (push || bypass) ? sel : '0;
    end
`else
    // Stored path only; a flit is always registered before leaving.
    always_comb begin
        req       = rst_n && (write_i != '0);
        bypass    = 1'b0;
        valid_o   = !empty_o;
        data_o    = head;
        pop       = valid_o && ready_i;
        push      = req && (!full_o || pop);
        fifo_push = push;
        ack_o     = push ? sel : '0;
    end
`endif

    flit_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (fifo_push),
        .wr_data (sel_data),
        .pop     (pop),
        .rd_data (head),
        .count   (count_o),
        .full    (full_o),
        .empty   (empty_o)
    );

endmodule
